// File: rtl/ss_display_ultra.sv
// Eight-digit multiplexed seven-segment driver with an independent programmable clock divider.
// All outputs are registered; reset is synchronous and active-low.
module ss_display_ultra #(
  parameter int SCAN_DIV = 100000,
  parameter int DP_DIGIT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [27:0] divisor,
  output logic        o_clk,
  input  logic [31:0] data_BCD,
  input  logic        DP,
  output logic [7:0]  light_code,
  output logic [6:0]  decode,
  output logic        DP_out
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

  logic [27:0] r_dcnt;
  logic        r_o_clk;
  logic [SW-1:0] r_scnt;
  logic [2:0]  r_idx;
  logic [7:0]  r_light;
  logic [6:0]  r_decode;
  logic        r_dp_out;

  logic        w_div_short;
  logic [27:0] w_div_m1;
  logic [27:0] w_dcnt_nxt;
  logic        w_o_clk_nxt;
  logic [3:0]  w_nibble;
  logic [6:0]  w_seg;

  // Divider: compare against the live divisor so a shrinking divisor wraps at once.
  assign w_div_short = (divisor < 28'd2);
  assign w_div_m1    = divisor - 28'd1;

  always_comb begin
    w_dcnt_nxt  = 28'd0;
    w_o_clk_nxt = 1'b0;
    if (!w_div_short) begin
      w_dcnt_nxt  = (r_dcnt >= w_div_m1) ? 28'd0 : r_dcnt + 28'd1;
      w_o_clk_nxt = (w_dcnt_nxt >= (divisor >> 1));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_dcnt  <= 28'd0;
      r_o_clk <= 1'b0;
    end else begin
      r_dcnt  <= w_dcnt_nxt;
      r_o_clk <= w_o_clk_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_scnt <= '0;
      r_idx  <= 3'd0;
    end else if (r_scnt == SCAN_LAST) begin
      r_scnt <= '0;
      r_idx  <= r_idx + 3'd1;
    end else begin
      r_scnt <= r_scnt + 1'b1;
    end
  end

  assign w_nibble = data_BCD[{r_idx, 2'b00} +: 4];

  // Active-low {g,f,e,d,c,b,a}; A shows a dash, B-F are blank.
  always_comb begin
    w_seg = 7'h7F;
    case (w_nibble)
      4'h0: w_seg = 7'h40;
      4'h1: w_seg = 7'h79;
      4'h2: w_seg = 7'h24;
      4'h3: w_seg = 7'h30;
      4'h4: w_seg = 7'h19;
      4'h5: w_seg = 7'h12;
      4'h6: w_seg = 7'h02;
      4'h7: w_seg = 7'h78;
      4'h8: w_seg = 7'h00;
      4'h9: w_seg = 7'h10;
      4'hA: w_seg = 7'h3F;
      default: w_seg = 7'h7F;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_light  <= 8'hFF;
      r_decode <= 7'h7F;
      r_dp_out <= 1'b1;
    end else begin
      r_light  <= ~(8'd1 << r_idx);
      r_decode <= w_seg;
      r_dp_out <= ~(DP && (r_idx == 3'(DP_DIGIT)));
    end
  end

  assign o_clk      = r_o_clk;
  assign light_code = r_light;
  assign decode     = r_decode;
  assign DP_out     = r_dp_out;

endmodule

// File: tb/tb_ss_display_ultra.sv
// Testbench for ss_display_ultra: vector table, hand-written divider/reset sequences,
// and a randomized run against a cycle-count based reference model.
module tb_ss_display_ultra;

  localparam int SCAN = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [27:0] divisor;
  logic        o_clk;
  logic [31:0] data_BCD;
  logic        DP;
  logic [7:0]  light_code;
  logic [6:0]  decode;
  logic        DP_out;

  int n_cmp = 0;
  int n_bad = 0;

  logic [6:0] SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h3F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};

  ss_display_ultra #(.SCAN_DIV(SCAN), .DP_DIGIT(0)) dut (
    .clk(clk), .rst_n(rst_n), .divisor(divisor), .o_clk(o_clk),
    .data_BCD(data_BCD), .DP(DP), .light_code(light_code),
    .decode(decode), .DP_out(DP_out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " light"}, 32'(light_code), 32'hFF);
    check({tag, " decode"}, 32'(decode), 32'h7F);
    check({tag, " dp"}, 32'(DP_out), 32'h1);
    check({tag, " oclk"}, 32'(o_clk), 32'h0);
  endtask

  typedef struct {
    logic [31:0] data;
    logic        dp;
    int          digit;
    logic [7:0]  exp_light;
    logic [6:0]  exp_dec;
    logic        exp_dp;
  } vec_t;

  vec_t vecs [16];

  task automatic run_div(input int div, input int cycles);
    logic exp;
    rst_n = 1'b0; divisor = 28'(div);
    step();
    rst_n = 1'b1;
    for (int n = 1; n <= cycles; n++) begin
      step();
      exp = (div < 2) ? 1'b0 : ((n % div) >= (div / 2));
      check($sformatf("div%0d n%0d", div, n), 32'(o_clk), 32'(exp));
    end
  endtask

  initial begin
    int n, d, digit, div;
    logic p_rst, p_dp;
    logic [31:0] p_data;
    logic [27:0] p_div;
    logic [7:0] e_light;
    logic [6:0] e_dec;
    logic e_dp, e_o;

    vecs[0]  = '{32'h76543210, 1'b0, 0, 8'hFE, 7'h40, 1'b1};
    vecs[1]  = '{32'h76543210, 1'b0, 1, 8'hFD, 7'h79, 1'b1};
    vecs[2]  = '{32'h76543210, 1'b0, 2, 8'hFB, 7'h24, 1'b1};
    vecs[3]  = '{32'h76543210, 1'b0, 3, 8'hF7, 7'h30, 1'b1};
    vecs[4]  = '{32'h76543210, 1'b0, 4, 8'hEF, 7'h19, 1'b1};
    vecs[5]  = '{32'h76543210, 1'b0, 5, 8'hDF, 7'h12, 1'b1};
    vecs[6]  = '{32'h76543210, 1'b0, 6, 8'hBF, 7'h02, 1'b1};
    vecs[7]  = '{32'h76543210, 1'b0, 7, 8'h7F, 7'h78, 1'b1};
    vecs[8]  = '{32'hFFFFFF10, 1'b0, 0, 8'hFE, 7'h40, 1'b1};
    vecs[9]  = '{32'hFFFFFF10, 1'b0, 1, 8'hFD, 7'h79, 1'b1};
    vecs[10] = '{32'hFFFFFF10, 1'b0, 2, 8'hFB, 7'h7F, 1'b1};
    vecs[11] = '{32'hFFFFFF10, 1'b0, 7, 8'h7F, 7'h7F, 1'b1};
    vecs[12] = '{32'h0000A000, 1'b0, 3, 8'hF7, 7'h3F, 1'b1};
    vecs[13] = '{32'h0000000A, 1'b1, 0, 8'hFE, 7'h3F, 1'b0};
    vecs[14] = '{32'h98000000, 1'b1, 6, 8'hBF, 7'h00, 1'b1};
    vecs[15] = '{32'h98000000, 1'b1, 7, 8'h7F, 7'h10, 1'b1};

    rst_n = 1'b0; divisor = 28'd10; data_BCD = 32'h0; DP = 1'b0;

    for (int i = 0; i < 3; i++) begin
      data_BCD = $urandom; DP = 1'($urandom); divisor = 28'($urandom_range(0, 30));
      step();
      check_reset_vals($sformatf("reset%0d", i));
    end

    foreach (vecs[i]) begin
      rst_n = 1'b0; data_BCD = vecs[i].data; DP = vecs[i].dp; divisor = 28'd10;
      step();
      rst_n = 1'b1;
      repeat (SCAN * vecs[i].digit + 1) step();
      check($sformatf("vec%0d light", i), 32'(light_code), 32'(vecs[i].exp_light));
      check($sformatf("vec%0d decode", i), 32'(decode), 32'(vecs[i].exp_dec));
      check($sformatf("vec%0d dp", i), 32'(DP_out), 32'(vecs[i].exp_dp));
    end

    DP = 1'b0;
    run_div(10, 30);
    run_div(7, 21);
    run_div(1, 10);
    run_div(0, 5);
    run_div(2, 6);

    // Reset pulse while digit 5 is shown and the divider is mid-period.
    rst_n = 1'b0; data_BCD = 32'h76543210; divisor = 28'd10; DP = 1'b1;
    step();
    rst_n = 1'b1;
    repeat (SCAN * 5 + 3) step();
    check("midscan light", 32'(light_code), 32'hDF);
    rst_n = 1'b0;
    step();
    check_reset_vals("midscan rst");
    rst_n = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      check($sformatf("restart oclk%0d", k), 32'(o_clk), 32'((k % 10) >= 5));
      if (k == 1) begin
        check("restart light", 32'(light_code), 32'hFE);
        check("restart dp", 32'(DP_out), 32'h0);
      end
    end

    // Randomized run: expectations from the cycle count since reset.
    rst_n = 1'b0;
    step();
    n = 0; d = 0;
    for (int c = 0; c < 3000; c++) begin
      p_rst = ($urandom_range(0, 199) != 0);
      p_data = $urandom;
      p_dp = 1'($urandom);
      if ($urandom_range(0, 49) == 0) begin
        case ($urandom_range(0, 6))
          0: p_div = 28'd0;
          1: p_div = 28'd1;
          2: p_div = 28'd2;
          3: p_div = 28'd3;
          4: p_div = 28'd7;
          5: p_div = 28'd10;
          default: p_div = 28'($urandom_range(2, 40));
        endcase
      end else begin
        p_div = divisor;
      end
      rst_n = p_rst; data_BCD = p_data; DP = p_dp; divisor = p_div;
      step();
      if (!p_rst) begin
        n = 0; d = 0;
        e_light = 8'hFF; e_dec = 7'h7F; e_dp = 1'b1; e_o = 1'b0;
      end else begin
        n++;
        div = int'(p_div);
        if (div < 2) d = 0;
        else if (d >= div - 1) d = 0;
        else d++;
        e_o = (div >= 2) && (d >= div / 2);
        digit = ((n - 1) / SCAN) % 8;
        e_light = 8'hFF ^ (8'h01 << digit);
        e_dec = SEG[(p_data >> (4 * digit)) & 32'hF];
        e_dp = !(p_dp && digit == 0);
      end
      check($sformatf("rnd%0d light", c), 32'(light_code), 32'(e_light));
      check($sformatf("rnd%0d decode", c), 32'(decode), 32'(e_dec));
      check($sformatf("rnd%0d dp", c), 32'(DP_out), 32'(e_dp));
      check($sformatf("rnd%0d oclk", c), 32'(o_clk), 32'(e_o));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ss_display_ultra.md
SS_DISPLAY_ULTRA -- requirements
Module: ss_display_ultra

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 100000, clk cycles each digit stays active (must be >= 1).
REQ-002 SHALL have parameter DP_DIGIT, default 0, digit index (0..7) on which the DP input is shown.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, synchronous and active-low.
REQ-005 SHALL have port divisor, input, 28, period of o_clk in clk cycles.
REQ-006 SHALL have port o_clk, output, 1, divided clock, registered.
REQ-007 SHALL have port data_BCD, input, 32, digit i = data_BCD[4i+3:4i], i = 0..7.
REQ-008 SHALL have port DP, input, 1, decimal-point request (1 = lit).
REQ-009 SHALL have port light_code, output, 8, active-low one-hot digit enable; bit i = digit i.
REQ-010 SHALL have port decode, output, 7, active-low segments {g,f,e,d,c,b,a}.
REQ-011 SHALL have port DP_out, output, 1, active-low decimal-point segment.

Function
REQ-012 Divider SHALL keep a 28-bit counter dcnt: if dcnt >= divisor-1 then dcnt <= 0, else dcnt <= dcnt+1.
REQ-013 o_clk SHALL be registered as 1 when the next dcnt >= divisor>>1, else 0, giving period = divisor cycles: low for the first floor(divisor/2) cycles, high for the rest.
REQ-014 When divisor < 2, dcnt SHALL be held at 0 and o_clk held at 0.
REQ-015 A divisor change mid-count SHALL take effect immediately; if dcnt >= new divisor-1, dcnt wraps to 0 on the next edge (no overrun).
REQ-016 Scanner SHALL keep a prescaler scnt (0..SCAN_DIV-1) and a 3-bit digit index idx.
REQ-017 idx SHALL increment when scnt = SCAN_DIV-1, then scnt returns to 0; idx wraps from 7 to 0.
REQ-018 Each cycle, the registered outputs SHALL load from the current idx and data_BCD, giving 1-cycle latency from idx or data change.
REQ-019 light_code SHALL be ~(8'b1 << idx), so exactly one bit is low outside reset.
REQ-020 decode SHALL map the nibble as (hex, active-low): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=3F ('-', segment g only), B-F=7F (blank).
REQ-021 DP_out SHALL be 0 only when DP=1 and idx = DP_DIGIT; otherwise 1.
REQ-022 The divider and scanner SHALL run independently; o_clk SHALL NOT affect the scan.

Reset
REQ-023 While rst_n=0 at a clk edge: dcnt=0, o_clk=0, scnt=0, idx=0, light_code=FF, decode=7F, DP_out=1.
REQ-024 On the first edge with rst_n=1, outputs SHALL show digit 0, then scan normally.
REQ-025 Reset asserted mid-scan or mid-period SHALL take effect on the next edge regardless of state.

Verification
REQ-026 rst_n=0 for 3 cycles, any inputs -> light_code=FF, decode=7F, DP_out=1, o_clk=0 every cycle.
REQ-027 divisor=10 -> o_clk repeats 5 cycles 0, 5 cycles 1; divisor=7 -> 3 low, 4 high; divisor=1 -> o_clk stuck 0.
REQ-028 SCAN_DIV=4, data_BCD=76543210 -> light_code FE,FD,FB,F7,EF,DF,BF,7F, each for 4 cycles, with decode 40,79,24,30,19,12,02,78, then repeats.
REQ-029 data_BCD=FFFFFF10 -> digits 2..7 decode=7F, digit 1 = 79, digit 0 = 40; nibble A on any digit -> 3F.
REQ-030 DP=1, DP_DIGIT=0 -> DP_out=0 only while light_code=FE; DP=0 -> DP_out always 1.
REQ-031 rst_n pulsed low while idx=5 and dcnt mid-period -> next edge all reset values; the scan restarts at digit 0 and the o_clk low phase restarts in full.
